// File: rtl/change_pkg.sv
// Shared types and constants for the change payout controller.
package change_pkg;

  localparam int unsigned AMT_W = 6;
  localparam int unsigned SEL_W = 2;

  // Coin values in 0.5-unit counts
  localparam logic [AMT_W-1:0] DEN_1  = AMT_W'(1);
  localparam logic [AMT_W-1:0] DEN_5  = AMT_W'(5);
  localparam logic [AMT_W-1:0] DEN_10 = AMT_W'(10);

  // eject_sel encodings; 2'd3 is never driven
  localparam logic [SEL_W-1:0] SEL_1  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_5  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_10 = SEL_W'(2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_GAP,
    ST_DONE,
    ST_FAULT
  } state_t;

endpackage

// File: rtl/denom_sel.sv
// Greedy coin selector: largest denomination not exceeding the amount owed.
import change_pkg::*;

module denom_sel (
  input  logic [AMT_W-1:0] remaining,
  output logic [SEL_W-1:0] sel,
  output logic [AMT_W-1:0] value
);

  // Pick the largest coin that fits
  always_comb begin
    sel   = SEL_1;
    value = DEN_1;
    if (remaining >= DEN_10) begin
      sel   = SEL_10;
      value = DEN_10;
    end else if (remaining >= DEN_5) begin
      sel   = SEL_5;
      value = DEN_5;
    end
  end

endmodule

// File: rtl/change_ctrl.sv
// Change payout controller: ejects coins one at a time with a handshake.
// Optional ack timeout enabled by defining CHANGE_CTRL_TIMEOUT_EN.
import change_pkg::*;

module change_ctrl #(
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned ACK_TMO = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             eject_ack,
  output logic             eject_req,
  output logic [SEL_W-1:0] eject_sel,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] remaining
);

  // One cycle counter serves both the GAP wait and the REQ timeout
  localparam int unsigned CNT_MAX = (GAP_CYC > ACK_TMO) ? GAP_CYC : ACK_TMO;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
`ifdef CHANGE_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TMO - 1);
`endif

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [AMT_W-1:0] coin_val, coin_val_d;
  logic [AMT_W-1:0] remaining_d;
  logic [SEL_W-1:0] eject_sel_d;
  logic             eject_req_d, busy_d, done_d, fault_d;
  logic [SEL_W-1:0] sel_c;
  logic [AMT_W-1:0] val_c;

  denom_sel u_denom_sel (
    .remaining (remaining),
    .sel       (sel_c),
    .value     (val_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (start) state_d = (change_amt == '0) ? ST_DONE : ST_SELECT;
      ST_SELECT: state_d = ST_REQ;
      ST_REQ: begin
        if (eject_ack) state_d = ST_GAP;
`ifdef CHANGE_CTRL_TIMEOUT_EN
        else if (cnt == TMO_LAST) state_d = ST_FAULT;
`endif
      end
      ST_GAP: begin
        if (cnt >= GAP_LAST && !eject_ack)
          state_d = (remaining == '0) ? ST_DONE : ST_SELECT;
      end
      ST_DONE:   state_d = ST_IDLE;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; outputs follow the next state
  always_comb begin
    cnt_d       = '0;
    coin_val_d  = coin_val;
    remaining_d = remaining;
    eject_req_d = 1'b0;
    eject_sel_d = SEL_1;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    fault_d     = 1'b0;

    if (state_d == state) cnt_d = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    case (state)
      ST_IDLE:   if (start) remaining_d = change_amt;
      ST_SELECT: coin_val_d = val_c;
      ST_REQ:    if (eject_ack) remaining_d = remaining - coin_val;
      default:   ;
    endcase

    eject_req_d = (state_d == ST_REQ);
    if (state_d == ST_REQ) eject_sel_d = (state == ST_SELECT) ? sel_c : eject_sel;
    busy_d = state_d inside {ST_SELECT, ST_REQ, ST_GAP, ST_DONE};
    done_d = (state == ST_DONE);
`ifdef CHANGE_CTRL_TIMEOUT_EN
    fault_d = (state_d == ST_FAULT);
`endif
  end

  // Registered outputs and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      coin_val  <= '0;
      remaining <= '0;
      eject_req <= 1'b0;
      eject_sel <= SEL_1;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      coin_val  <= coin_val_d;
      remaining <= remaining_d;
      eject_req <= eject_req_d;
      eject_sel <= eject_sel_d;
      busy      <= busy_d;
      done      <= done_d;
      fault     <= fault_d;
    end
  end

endmodule

// File: tb/tb_change_ctrl.sv
// Directed testbench for change_ctrl.
module tb_change_ctrl;
  import change_pkg::*;

  localparam int unsigned GAP_CYC = 2;
  localparam int unsigned ACK_TMO = 8;

  logic             clk = 1'b0;
  logic             rst, start, eject_ack;
  logic [AMT_W-1:0] change_amt;
  logic             eject_req, busy, done, fault;
  logic [SEL_W-1:0] eject_sel;
  logic [AMT_W-1:0] remaining;

  change_ctrl #(.GAP_CYC(GAP_CYC), .ACK_TMO(ACK_TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .change_amt (change_amt),
    .eject_ack  (eject_ack),
    .eject_req  (eject_req),
    .eject_sel  (eject_sel),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .remaining  (remaining)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Payout observation log
  int         coins, done_cnt, min_gap, sel_bad;
  int         sel_cnt[4];
  bit         timed_out;
  logic [1:0] sel_log[$];
  logic [5:0] rem_log[$];

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acknowledge each request one cycle after it appears; log until done settles
  task automatic serve(input int budget);
    int  age = 0;
    int  low = 0;
    int  post = 0;
    bit  prev_req = 1'b0;
    bit  seen_req = 1'b0;
    coins = 0; done_cnt = 0; min_gap = 999; sel_bad = 0; timed_out = 1'b1;
    foreach (sel_cnt[i]) sel_cnt[i] = 0;
    sel_log.delete();
    rem_log.delete();
    for (int c = 0; c < budget; c++) begin
      if (done) done_cnt++;
      if (!eject_req && eject_sel != 2'd0) sel_bad++;
      if (eject_req && !prev_req) begin
        sel_log.push_back(eject_sel);
        sel_cnt[eject_sel]++;
        coins++;
        if (seen_req && low < min_gap) min_gap = low;
        seen_req = 1'b1;
      end
      if (!eject_req && prev_req) rem_log.push_back(remaining);
      if (eject_req) begin low = 0; age++; end
      else begin low++; age = 0; end
      eject_ack = eject_req && (age >= 2);
      prev_req = eject_req;
      if (done_cnt > 0 && !busy) post++;
      if (post >= 3) begin timed_out = 1'b0; break; end
      tick();
    end
    eject_ack = 1'b0;
  endtask

  task automatic run_pay(input logic [5:0] amt);
    change_amt = amt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("busy_after_start_%0d", amt), busy, 1);
    serve(400);
    check($sformatf("timeout_%0d", amt), timed_out, 0);
    check($sformatf("done_once_%0d", amt), done_cnt, 1);
    check($sformatf("sel_idle_zero_%0d", amt), sel_bad, 0);
    check($sformatf("rem_end_%0d", amt), remaining, 0);
  endtask

  function automatic int unsigned pack_sel();
    int unsigned v = 0;
    foreach (sel_log[i]) v = (v << 2) | int'(sel_log[i]);
    return v;
  endfunction

  function automatic int unsigned pack_rem();
    int unsigned v = 0;
    foreach (rem_log[i]) v = (v << 6) | int'(rem_log[i]);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst = 1'b1; start = 1'b1; change_amt = 6'd5; eject_ack = 1'b0;
    tick(); tick();
    check("rst_req", eject_req, 0);
    check("rst_sel", eject_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_rem", remaining, 0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("start_in_rst_ignored", busy, 0);

    // 17 -> 10,5,1,1
    run_pay(6'd17);
    check("coins_17", coins, 4);
    check("sels_17", pack_sel(), 8'({2'd2, 2'd1, 2'd0, 2'd0}));
    check("rems_17", pack_rem(), 24'({6'd7, 6'd2, 6'd1, 6'd0}));

    // Zero amount: done two cycles after start, no request
    change_amt = 6'd0; start = 1'b1;
    tick(); start = 1'b0;
    check("zero_d1_done", done, 0);
    check("zero_d1_busy", busy, 1);
    check("zero_d1_req", eject_req, 0);
    tick();
    check("zero_d2_done", done, 1);
    check("zero_d2_busy", busy, 0);
    check("zero_d2_rem", remaining, 0);
    tick();
    check("zero_d3_done", done, 0);

    // 63 -> six 10s, three 1s
    run_pay(6'd63);
    check("coins_63", coins, 9);
    check("sel10_63", sel_cnt[2], 6);
    check("sel5_63", sel_cnt[1], 0);
    check("sel1_63", sel_cnt[0], 3);
    check("gap_63", int'(min_gap >= int'(GAP_CYC)), 1);
    check("rem_first_63", rem_log[0], 53);

    // 9 -> 5,1,1,1,1
    run_pay(6'd9);
    check("coins_9", coins, 5);
    check("sels_9", pack_sel(), 10'({2'd1, 2'd0, 2'd0, 2'd0, 2'd0}));

    // Ack held high from start: one coin accepted until ack drops
    eject_ack = 1'b1; change_amt = 6'd6; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    check("hold_req", eject_req, 1);
    check("hold_rem6", remaining, 6);
    tick();
    check("hold_req_low", eject_req, 0);
    check("hold_rem1", remaining, 1);
    bad = 0;
    repeat (6) begin
      tick();
      if (eject_req || remaining != 6'd1) bad++;
    end
    check("hold_stall", bad, 0);
    eject_ack = 1'b0;
    serve(200);
    check("hold_timeout", timed_out, 0);
    check("hold_coins", coins, 1);
    check("hold_sel", pack_sel(), 0);
    check("hold_rem_end", remaining, 0);

    // No ack at all
    change_amt = 6'd12; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    check("nack_req_rise", eject_req, 1);
    repeat (7) tick();
    check("nack_fault_pre", fault, 0);
    tick();
`ifdef CHANGE_CTRL_TIMEOUT_EN
    check("nack_fault", fault, 1);
    check("nack_req", eject_req, 0);
    check("nack_busy", busy, 0);
`else
    check("nack_fault", fault, 0);
    check("nack_req", eject_req, 1);
    check("nack_busy", busy, 1);
`endif
    check("nack_rem", remaining, 12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("nack_rst_fault", fault, 0);

    // Reset in the middle of REQ, with start held during reset
    change_amt = 6'd12; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    check("rmid_req", eject_req, 1);
    rst = 1'b1; start = 1'b1;
    tick();
    check("rmid_req0", eject_req, 0);
    check("rmid_sel0", eject_sel, 0);
    check("rmid_busy0", busy, 0);
    check("rmid_done0", done, 0);
    check("rmid_fault0", fault, 0);
    check("rmid_rem0", remaining, 0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("rmid_start_ignored", busy, 0);
    run_pay(6'd12);
    check("coins_12", coins, 3);
    check("sels_12", pack_sel(), 6'({2'd2, 2'd0, 2'd0}));
    check("rems_12", pack_rem(), 18'({6'd2, 6'd1, 6'd0}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/change_ctrl.md
CHANGE_CTRL -- requirements
Module: change_ctrl

Interface
REQ-001 Parameter GAP_CYC, 2: idle cycles with eject_req low between two ejections (range 1..15).
REQ-002 Parameter ACK_TMO, 8: cycles of eject_req high without eject_ack before fault (range 2..255); used only when CHANGE_CTRL_TIMEOUT_EN is defined.
REQ-003 clk  input  1  system clock (1 Hz FSM domain); all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse: begin payout of change_amt.
REQ-006 change_amt  input  6  change to return, in 0.5-unit coin counts (0..63), sampled on start.
REQ-007 eject_ack  input  1  coin mechanism acknowledge, level.
REQ-008 eject_req  output  1  request one coin ejection.
REQ-009 eject_sel  output  2  denomination of requested coin: 2'd0=1, 2'd1=5, 2'd2=10 units; 2'd3 unused.
REQ-010 busy  output  1  high from cycle after accepted start until DONE/FAULT exit.
REQ-011 done  output  1  one-cycle pulse, payout complete.
REQ-012 fault  output  1  level, set on ack timeout; cleared only by rst.
REQ-013 remaining  output  6  change still owed.

Function
REQ-014 States SHALL be IDLE, SELECT, REQ, GAP, DONE, FAULT.
REQ-015 IDLE: start=1 latches change_amt into remaining; amt=0 -> DONE, else -> SELECT; start ignored in every other state.
REQ-016 SELECT (1 cycle): greedy choice -- remaining>=10 -> sel 2, else >=5 -> sel 1, else sel 0; -> REQ.
REQ-017 REQ: eject_req=1, eject_sel held stable; first cycle eject_ack sampled high -> remaining -= chosen denomination (6-bit, never underflows), -> GAP.
REQ-018 GAP: eject_req=0 for GAP_CYC cycles and until eject_ack sampled low; then remaining=0 -> DONE, else -> SELECT.
REQ-019 eject_ack high on entry to REQ (stale ack) SHALL NOT count; ack must be seen low at least one cycle after GAP before a new REQ is accepted (guaranteed by REQ-018).
REQ-020 DONE (1 cycle): done=1, busy=0 on next cycle, -> IDLE.
REQ-021 Latency: start to first eject_req = 2 cycles (IDLE->SELECT->REQ).
REQ-022 eject_sel SHALL be 0 whenever eject_req=0.
REQ-023 Coin count for amt N SHALL equal floor(N/10)+floor((N mod 10)/5)+(N mod 5).

Reset
REQ-024 rst SHALL force IDLE, eject_req=0, eject_sel=0, busy=0, done=0, fault=0, remaining=0, all counters 0, regardless of state (including mid-REQ).
REQ-025 start asserted in the rst cycle SHALL be ignored.

Configuration
REQ-026 Macro CHANGE_CTRL_TIMEOUT_EN defined: counter runs in REQ; ACK_TMO consecutive cycles without ack -> FAULT (eject_req=0, fault=1, busy=0, remaining frozen), exit only by rst.
REQ-027 Macro undefined: no timeout counter, FAULT state unreachable, fault tied 0, REQ waits indefinitely.

Structure
REQ-028 Shared package change_pkg SHALL hold state enum type, denomination constants (DEN_1=1, DEN_5=5, DEN_10=10) and eject_sel encodings.
REQ-029 One sub-module, denom_sel (combinational greedy selector: remaining -> sel, value), is natural; counters and FSM stay in change_ctrl.

Verification
REQ-030 change_amt=17, ack 1 cycle after each req -> sel sequence 2,1,0,0; remaining 7,2,1,0; done pulse once; 4 coins.
REQ-031 change_amt=0 -> no eject_req, done pulse 2 cycles after start, remaining=0.
REQ-032 change_amt=63 -> 6x sel2, 0x sel1, 3x sel0 (9 coins); gap of >=GAP_CYC low cycles between reqs.
REQ-033 ack held high continuously from start -> only first REQ accepted until ack drops; remaining decrements once per ack low-high cycle.
REQ-034 TIMEOUT_EN, ACK_TMO=8, no ack -> fault=1 exactly 8 cycles after eject_req rises, eject_req=0, busy=0; without macro eject_req stays high.
REQ-035 rst asserted mid-REQ with change_amt=12 -> next cycle all outputs at reset values; subsequent start accepted normally.
